// File: rtl/lsu_mem_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// lsu_mem_ctrl_pkg
// Shared definitions for the load/store memory controller:
//   - sel encodings as presented by the execute stage (SEL_LW..SEL_LHU)
//   - FSM state codes
//   - byte-enable base patterns (shifted by the byte offset at use)
//   - helpers that reduce sel to an access size and test alignment
// -----------------------------------------------------------------------------
package lsu_mem_ctrl_pkg;

  // sel encodings. Stores only look at the size implied by these codes.
  localparam logic [2:0] SEL_LW  = 3'b000;
  localparam logic [2:0] SEL_LB  = 3'b001;
  localparam logic [2:0] SEL_LH  = 3'b010;
  localparam logic [2:0] SEL_LBU = 3'b011;
  localparam logic [2:0] SEL_LHU = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SZ_WORD = 2'd0,
    SZ_HALF = 2'd1,
    SZ_BYTE = 2'd2
  } size_e;

  // Byte-enable patterns for an access at byte offset 0.
  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  // Unused sel codes (101..111) are treated as word accesses.
  function automatic size_e sel_size(input logic [2:0] sel);
    case (sel)
      SEL_LB, SEL_LBU: return SZ_BYTE;
      SEL_LH, SEL_LHU: return SZ_HALF;
      default:         return SZ_WORD;
    endcase
  endfunction

  function automatic logic is_misaligned(input size_e sz, input logic [1:0] off);
    case (sz)
      SZ_HALF: return off[0];
      SZ_WORD: return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_store_align.sv
// -----------------------------------------------------------------------------
// lsu_store_align
// Combinational store formatter: byte enables and lane-replicated write data.
// Replicating the low byte/half into every lane lets the bus pick whichever
// lane the byte enables select, so no data shift is needed.
// Ports:
//   sel_i     [2:0]  access type (only the size matters here)
//   offset_i  [1:0]  byte offset within the word (addr[1:0])
//   wdata_i   [31:0] store value, right-aligned
//   be_o      [3:0]  byte enables
//   wdata_o   [31:0] replicated store data
// -----------------------------------------------------------------------------
module lsu_store_align (
  input  logic [2:0]  sel_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o
);
  import lsu_mem_ctrl_pkg::*;

  // NOTE: every output of a combinational block gets a default before the
  // case, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    be_o    = BE_WORD;
    wdata_o = wdata_i;
    case (sel_size(sel_i))
      SZ_BYTE: begin
        be_o    = BE_BYTE << offset_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      SZ_HALF: begin
        be_o    = BE_HALF << offset_i;
        wdata_o = {2{wdata_i[15:0]}};
      end
      default: begin
        be_o    = BE_WORD;
        wdata_o = wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_mem_ctrl
// Load/store controller between execute and a req/gnt/rvalid data bus.
// One access per instruction: IDLE -> REQ -> RESP -> DONE -> IDLE (stores
// skip RESP, misaligned accesses go straight to DONE without a bus request).
// Loads return the word shifted right so the addressed byte/half lands in
// bits [15:0]; ld_sel tells the load-extend stage how to extend it.
// Parameters:
//   TIMEOUT  cycles an access may spend in REQ+RESP before bus_err (>=2)
//   CNT_W    timeout counter width, must hold TIMEOUT
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   mem_read, mem_write         access request from execute (mutually exclusive)
//   addr, wdata, sel            byte address, store data, access type
//   stall                       freeze pipeline while the access is in flight
//   ld_data, ld_sel             aligned load word and its sel, held until next load
//   done, misalign, bus_err     one-cycle completion pulse and its status flags
//   mem_req/we/addr/be/wdata    bus request side
//   mem_gnt, mem_rvalid, mem_rdata  bus response side
// -----------------------------------------------------------------------------
module lsu_mem_ctrl #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  sel,
  output logic        stall,
  output logic [31:0] ld_data,
  output logic [2:0]  ld_sel,
  output logic        done,
  output logic        misalign,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);
  import lsu_mem_ctrl_pkg::*;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             misalign_q, misalign_d;
  logic             bus_err_q, bus_err_d;

  logic [1:0]       off_q;
  logic [2:0]       sel_q;
  logic             we_q;
  logic [31:0]      mem_addr_q;
  logic [3:0]       mem_be_q;
  logic [31:0]      mem_wdata_q;
  logic [31:0]      ld_data_q;
  logic [2:0]       ld_sel_q;

  logic [3:0]       st_be;
  logic [31:0]      st_wdata;
  logic             access;
  logic             accept;
  logic             load_done;
  logic             timeout;

  lsu_store_align u_store_align (
    .sel_i    (sel),
    .offset_i (addr[1:0]),
    .wdata_i  (wdata),
    .be_o     (st_be),
    .wdata_o  (st_wdata)
  );

  assign access    = mem_read | mem_write;
  assign accept    = (state_q == ST_IDLE) && access;
  assign load_done = (state_q == ST_RESP) && mem_rvalid;
  // ">=" rather than "==": a read granted on the last REQ cycle enters RESP
  // with the count already past TIMEOUT-1 and must still time out.
  assign timeout   = cnt_q >= CNT_W'(TIMEOUT - 1);

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      misalign_q <= misalign_d;
      bus_err_q  <= bus_err_d;
    end
  end

  // Request fields are captured once at acceptance so the bus sees stable
  // values for the whole REQ phase even if execute changes its inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      off_q       <= 2'b00;
      sel_q       <= SEL_LW;
      we_q        <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      ld_data_q   <= '0;
      ld_sel_q    <= SEL_LW;
    end else begin
      if (accept) begin
        off_q       <= addr[1:0];
        sel_q       <= sel;
        we_q        <= mem_write;
        mem_addr_q  <= {addr[31:2], 2'b00};
        mem_be_q    <= mem_write ? st_be : BE_WORD;
        mem_wdata_q <= st_wdata;
      end
      if (load_done) begin
        ld_data_q <= mem_rdata >> {off_q, 3'b000};
        ld_sel_q  <= sel_q;
      end
    end
  end

  // Flags are only ever set on the transition into DONE, so they are
  // automatically zero whenever done is low.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    misalign_d = 1'b0;
    bus_err_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (access) begin
          if (is_misaligned(sel_size(sel), addr[1:0])) begin
            state_d    = ST_DONE;
            misalign_d = 1'b1;
          end else begin
            state_d = ST_REQ;
            cnt_d   = '0;
          end
        end
      end
      ST_REQ: begin
        cnt_d = cnt_q + 1'b1;
        if (mem_gnt) begin
          state_d = we_q ? ST_DONE : ST_RESP;
        end else if (timeout) begin
          state_d   = ST_DONE;
          bus_err_d = 1'b1;
        end
      end
      ST_RESP: begin
        cnt_d = cnt_q + 1'b1;
        if (mem_rvalid) begin
          state_d = ST_DONE;
        end else if (timeout) begin
          state_d   = ST_DONE;
          bus_err_d = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // stall in IDLE follows the request combinationally so the instruction is
  // held from its first cycle; gating with rst_n keeps it low during reset.
  always_comb begin
    case (state_q)
      ST_IDLE:          stall = rst_n & access;
      ST_REQ, ST_RESP:  stall = 1'b1;
      default:          stall = 1'b0;
    endcase
  end

  assign done      = (state_q == ST_DONE);
  assign misalign  = misalign_q;
  assign bus_err   = bus_err_q;
  assign mem_req   = (state_q == ST_REQ);
  assign mem_we    = mem_req & we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
  assign ld_data   = ld_data_q;
  assign ld_sel    = ld_sel_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lsu_mem_ctrl
// Directed bench for lsu_mem_ctrl. Each transaction is described by its
// request and by when the bus grants / returns data; the bench derives the
// expected timeline (stall length, done cycle, flags, bus fields, aligned load
// data) from those numbers and a per-cycle compare process checks the DUT
// against it. A few hand-computed literals pin the model.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lsu_mem_ctrl;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read, mem_write;
  logic [31:0] addr, wdata;
  logic [2:0]  sel;
  logic        stall, done, misalign, bus_err;
  logic [31:0] ld_data;
  logic [2:0]  ld_sel;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  lsu_mem_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .addr       (addr),
    .wdata      (wdata),
    .sel        (sel),
    .stall      (stall),
    .ld_data    (ld_data),
    .ld_sel     (ld_sel),
    .done       (done),
    .misalign   (misalign),
    .bus_err    (bus_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        is_load;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  sel;
    int          gnt_dly;  // REQ cycle index on which gnt is given
    int          rv_dly;   // RESP cycle index on which rvalid is given
    logic [31:0] rdata;
  } txn_t;

  // Expected values for the current cycle, written by the driver.
  logic        exp_valid = 1'b0;
  logic        exp_stall, exp_done, exp_mis, exp_err, exp_req, exp_we;
  logic [31:0] exp_addr, exp_wd;
  logic [3:0]  exp_be;
  logic [31:0] m_ld_data = '0;
  logic [2:0]  m_ld_sel  = '0;

  // Running totals observed by the compare process.
  int          stall_tot = 0;
  int          req_tot   = 0;
  logic [31:0] seen_addr = '0, seen_wd = '0;
  logic [3:0]  seen_be   = '0;

  function automatic int size_of(input logic [2:0] s);
    if (s == 3'b001 || s == 3'b011) return 1;
    if (s == 3'b010 || s == 3'b100) return 2;
    return 4;
  endfunction

  // Reference load-extend stage, used to pin the sign/zero handoff.
  function automatic logic [31:0] extend(input logic [31:0] d, input logic [2:0] s);
    case (s)
      3'b001:  return {{24{d[7]}}, d[7:0]};
      3'b010:  return {{16{d[15]}}, d[15:0]};
      3'b011:  return {24'h0, d[7:0]};
      3'b100:  return {16'h0, d[15:0]};
      default: return d;
    endcase
  endfunction

  always @(negedge clk) begin
    if (stall === 1'b1) stall_tot <= stall_tot + 1;
    if (mem_req === 1'b1) begin
      req_tot   <= req_tot + 1;
      seen_addr <= mem_addr;
      seen_be   <= mem_be;
      seen_wd   <= mem_wdata;
    end
    if (exp_valid) begin
      check("stall",    32'(stall),    32'(exp_stall));
      check("done",     32'(done),     32'(exp_done));
      check("misalign", 32'(misalign), 32'(exp_mis));
      check("bus_err",  32'(bus_err),  32'(exp_err));
      check("mem_req",  32'(mem_req),  32'(exp_req));
      check("ld_data",  ld_data,       m_ld_data);
      check("ld_sel",   32'(ld_sel),   32'(m_ld_sel));
      if (exp_req) begin
        check("mem_we",   32'(mem_we), 32'(exp_we));
        check("mem_addr", mem_addr,    exp_addr);
        check("mem_be",   32'(mem_be), 32'(exp_be));
        if (exp_we) check("mem_wdata", mem_wdata, exp_wd);
      end else begin
        check("mem_we_idle", 32'(mem_we), 32'd0);
      end
    end
  end

  task automatic clear_exp();
    exp_stall = 1'b0; exp_done = 1'b0; exp_mis = 1'b0; exp_err = 1'b0; exp_req = 1'b0;
  endtask

  task automatic run_txn(input txn_t t);
    int   sz, off, n_req, n_resp, rem, total;
    logic mis, err;
    sz     = size_of(t.sel);
    off    = int'(t.addr % 4);
    mis    = (t.addr % sz) != 0;
    err    = 1'b0;
    n_req  = 0;
    n_resp = 0;
    if (!mis) begin
      if (t.gnt_dly >= TIMEOUT) begin
        n_req = TIMEOUT;
        err   = 1'b1;
      end else begin
        n_req = t.gnt_dly + 1;
        if (t.is_load) begin
          rem = (TIMEOUT - n_req > 0) ? TIMEOUT - n_req : 1;
          if (t.rv_dly >= rem) begin
            n_resp = rem;
            err    = 1'b1;
          end else begin
            n_resp = t.rv_dly + 1;
          end
        end
      end
    end
    exp_we   = !t.is_load;
    exp_addr = t.addr & ~32'h3;
    if (t.is_load || sz == 4) exp_be = 4'hF;
    else if (sz == 1)         exp_be = 4'(1 << off);
    else                      exp_be = 4'(3 << off);
    if (sz == 1)      exp_wd = {4{t.wdata[7:0]}};
    else if (sz == 2) exp_wd = {2{t.wdata[15:0]}};
    else              exp_wd = t.wdata;
    total = n_req + n_resp + 2;
    for (int c = 0; c < total; c++) begin
      @(posedge clk); #1;
      mem_read   = t.is_load;
      mem_write  = !t.is_load;
      addr       = t.addr;
      wdata      = t.wdata;
      sel        = t.sel;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = ~t.rdata;
      clear_exp();
      if (c == 0) begin
        exp_stall = 1'b1;
      end else if (c <= n_req) begin
        exp_stall = 1'b1;
        exp_req   = 1'b1;
        mem_gnt   = ((c - 1) == t.gnt_dly);
      end else if (c <= n_req + n_resp) begin
        exp_stall  = 1'b1;
        mem_rvalid = ((c - 1 - n_req) == t.rv_dly);
        if (mem_rvalid) mem_rdata = t.rdata;
      end else begin
        exp_done = 1'b1;
        exp_mis  = mis;
        exp_err  = err;
        if (t.is_load && !mis && !err) begin
          m_ld_data = t.rdata >> (8 * off);
          m_ld_sel  = t.sel;
        end
      end
    end
  endtask

  task automatic idle(input int n, input logic late);
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_gnt    = late;
      mem_rvalid = late;
      mem_rdata  = 32'h5555AAAA;
      clear_exp();
    end
  endtask

  function automatic txn_t mk(input logic ld, input logic [31:0] a, input logic [31:0] w,
                              input logic [2:0] s, input int g, input int r, input logic [31:0] rd);
    txn_t t;
    t.is_load = ld; t.addr = a; t.wdata = w; t.sel = s;
    t.gnt_dly = g;  t.rv_dly = r; t.rdata = rd;
    return t;
  endfunction

  int s0, r0;

  initial begin
    rst_n = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0; addr = '0; wdata = '0; sel = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    clear_exp();
    exp_we = 1'b0; exp_addr = '0; exp_be = '0; exp_wd = '0;
    #3;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_flags", {30'd0, misalign, bus_err}, 32'd0);
    check("rst_req_we", {30'd0, mem_req, mem_we}, 32'd0);
    check("rst_ld_data", ld_data, 32'd0);
    check("rst_ld_sel", 32'(ld_sel), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_be", 32'(mem_be), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    #19 rst_n = 1'b1;
    exp_valid = 1'b1;

    // lw 0x100, zero-wait bus
    s0 = stall_tot;
    run_txn(mk(1'b1, 32'h100, 32'h0, 3'b000, 0, 0, 32'hDEADBEEF));
    idle(1, 1'b0);
    check("lw_stall_cycles", 32'(stall_tot - s0), 32'd3);
    check("lw_ld_data", ld_data, 32'hDEADBEEF);
    check("lw_ld_sel", 32'(ld_sel), 32'd0);

    // lb (signed) 0x103
    run_txn(mk(1'b1, 32'h103, 32'h0, 3'b001, 0, 0, 32'h80112233));
    idle(1, 1'b0);
    check("lb_ld_byte", 32'(ld_data[7:0]), 32'h80);
    check("lb_ld_sel", 32'(ld_sel), 32'd1);
    check("lb_extended", extend(ld_data, ld_sel), 32'hFFFFFF80);

    // sh 0x102
    s0 = stall_tot;
    run_txn(mk(1'b0, 32'h102, 32'h0000ABCD, 3'b010, 0, 0, 32'h0));
    idle(1, 1'b0);
    check("sh_stall_cycles", 32'(stall_tot - s0), 32'd2);
    check("sh_mem_be", 32'(seen_be), 32'b1100);
    check("sh_mem_wdata", seen_wd, 32'hABCDABCD);
    check("sh_mem_addr", seen_addr, 32'h100);

    // misaligned lw 0x101 and sh 0x103: no bus request, one stall cycle
    s0 = stall_tot; r0 = req_tot;
    run_txn(mk(1'b1, 32'h101, 32'h0, 3'b000, 0, 0, 32'h0));
    idle(1, 1'b0);
    check("lw_mis_stall", 32'(stall_tot - s0), 32'd1);
    check("lw_mis_noreq", 32'(req_tot - r0), 32'd0);
    r0 = req_tot;
    run_txn(mk(1'b0, 32'h103, 32'h1234, 3'b010, 0, 0, 32'h0));
    idle(1, 1'b0);
    check("sh_mis_noreq", 32'(req_tot - r0), 32'd0);

    // lhu 0x106 with wait states on both phases
    run_txn(mk(1'b1, 32'h106, 32'h0, 3'b100, 2, 3, 32'h12345678));
    idle(1, 1'b0);
    check("lhu_ld_data", ld_data, 32'h00001234);

    // sb 0x201 with a delayed grant, sw 0x300
    run_txn(mk(1'b0, 32'h201, 32'hFFFFFF5A, 3'b001, 1, 0, 32'h0));
    idle(1, 1'b0);
    check("sb_mem_be", 32'(seen_be), 32'b0010);
    check("sb_mem_wdata", seen_wd, 32'h5A5A5A5A);
    run_txn(mk(1'b0, 32'h300, 32'hCAFEF00D, 3'b000, 0, 0, 32'h0));
    idle(1, 1'b0);

    // grant withheld for 20 cycles: timeout after 16 REQ cycles, late
    // gnt/rvalid in IDLE must be ignored
    r0 = req_tot;
    run_txn(mk(1'b1, 32'h400, 32'h0, 3'b000, 20, 0, 32'h77777777));
    idle(4, 1'b1);
    check("timeout_req_cycles", 32'(req_tot - r0), 32'd16);
    check("timeout_ld_held", ld_data, 32'h00001234);

    // read that times out waiting for rvalid
    run_txn(mk(1'b1, 32'h10, 32'h0, 3'b010, 3, 20, 32'h99999999));
    idle(1, 1'b0);

    // lbu at offset 0
    run_txn(mk(1'b1, 32'h20, 32'h0, 3'b011, 0, 1, 32'hA1B2C3F4));
    idle(1, 1'b0);
    check("lbu_extended", extend(ld_data, ld_sel), 32'h000000F4);

    // reset while in RESP
    exp_we = 1'b0; exp_addr = 32'h40; exp_be = 4'hF;
    @(posedge clk); #1;
    mem_read = 1'b1; addr = 32'h40; sel = 3'b000; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    clear_exp(); exp_stall = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b1; exp_req = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0; exp_req = 1'b0;
    @(negedge clk); #1;
    exp_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_mid_req", 32'(mem_req), 32'd0);
    check("rst_mid_stall", 32'(stall), 32'd0);
    check("rst_mid_we", 32'(mem_we), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    check("rst_mid_be", 32'(mem_be), 32'd0);
    m_ld_data = '0;
    m_ld_sel  = '0;
    @(posedge clk); #2;
    rst_n    = 1'b1;
    mem_read = 1'b0;
    clear_exp();
    exp_valid = 1'b1;
    idle(3, 1'b1);

    // back to normal operation after the abort
    run_txn(mk(1'b1, 32'h44, 32'h0, 3'b010, 0, 0, 32'hBEEF8001));
    idle(2, 1'b0);
    check("post_rst_ld", extend(ld_data, ld_sel), 32'hFFFF8001);

    exp_valid = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
